// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues word fetches ahead of decode and
// aligns 16/32-bit instructions at any halfword, including straddles.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 4,
    parameter int unsigned     MAX_OUT    = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter bit              COMPRESSED = 1'b1
) (
    input  logic            clk,
    input  logic            Rst_n,
    input  logic            prog_hold,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            ins_valid,
    output logic [31:0]     ins,
    output logic [XLEN-1:0] ins_pc,
    output logic            ins_comp,
    input  logic            ins_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] MAXO = CW'(MAX_OUT);
    localparam logic [CW:0]   DEPW = (CW + 1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [31:0]     mem_q [DEPTH];
    ptr_t            rd_q, wr_q;
    logic [CW-1:0]   cnt_q, out_q, drop_q;
    logic [XLEN-1:0] fpc_q, hpc_q;
    logic            off_q;

    logic            flush, issue, push, acc, do_pop;
    logic [CW:0]     inflight;
    logic [31:0]     lo, raw;
    logic [15:0]     nx_lo;
    logic            have1, have2, lo_c, hi_c;
    logic            v, comp, pop;
    logic [XLEN-1:0] tgt;

    assign flush    = prog_hold || redirect_valid;
    assign inflight = {1'b0, cnt_q} + {1'b0, out_q};
    assign imem_req = Rst_n && !flush && (out_q < MAXO) && (inflight < DEPW);
    assign issue    = imem_req && imem_gnt;
    assign push     = imem_rvalid && (drop_q == '0) && !flush;
    assign imem_addr = fpc_q;
    assign tgt      = prog_hold ? RESET_PC : redirect_pc;

    assign lo    = mem_q[rd_q];
    assign nx_lo = mem_q[rd_q + ptr_t'(1)][15:0];
    assign have1 = cnt_q != '0;
    assign have2 = cnt_q >= CW'(2);
    assign lo_c  = lo[1:0] != 2'b11;
    assign hi_c  = lo[17:16] != 2'b11;

    always_comb begin
        raw  = lo;
        v    = 1'b0;
        comp = 1'b0;
        pop  = 1'b0;
        unique case (1'b1)
            !COMPRESSED: begin
                v   = have1;
                pop = 1'b1;
            end
            COMPRESSED && !off_q && lo_c: begin
                raw  = {16'h0000, lo[15:0]};
                v    = have1;
                comp = 1'b1;
            end
            COMPRESSED && !off_q && !lo_c: begin
                v   = have1;
                pop = 1'b1;
            end
            COMPRESSED && off_q && hi_c: begin
                raw  = {16'h0000, lo[31:16]};
                v    = have1;
                comp = 1'b1;
                pop  = 1'b1;
            end
            COMPRESSED && off_q && !hi_c: begin
                raw = {nx_lo, lo[31:16]};
                v   = have2;
                pop = 1'b1;
            end
        endcase
    end

    // A redirect or hold cycle never presents an instruction.
    assign ins_valid = v && !flush;
    assign ins       = ins_valid ? raw : 32'h0;
    assign ins_comp  = ins_valid && comp;
    assign ins_pc    = hpc_q;
    assign acc       = ins_valid && ins_ready;
    assign do_pop    = acc && pop;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            drop_q <= '0;
            fpc_q  <= RESET_PC;
            hpc_q  <= RESET_PC;
            off_q  <= 1'b0;
        end else if (flush) begin
            // Anything still in flight belongs to the old stream.
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            out_q  <= out_q - CW'(imem_rvalid);
            drop_q <= out_q - CW'(imem_rvalid);
            fpc_q  <= {tgt[XLEN-1:2], 2'b00};
            hpc_q  <= tgt;
            off_q  <= COMPRESSED ? tgt[1] : 1'b0;
        end else begin
            if (issue) fpc_q <= fpc_q + XLEN'(4);
            out_q <= out_q + CW'(issue) - CW'(imem_rvalid);
            if (imem_rvalid && drop_q != '0) drop_q <= drop_q - CW'(1);
            if (push) begin
                mem_q[wr_q] <= imem_rdata;
                wr_q        <= wr_q + ptr_t'(1);
            end
            if (do_pop) rd_q <= rd_q + ptr_t'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
            if (acc) begin
                hpc_q <= hpc_q + (comp ? XLEN'(2) : XLEN'(4));
                off_q <= comp ? !off_q : off_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order imem model
// of configurable latency and an expected-instruction scoreboard.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        prog_hold = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_comp;
    logic        ins_ready = 1'b1;

    fetch_prefetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .MAX_OUT(2),
        .RESET_PC(32'h0), .COMPRESSED(1'b1)
    ) dut (
        .clk(clk), .Rst_n(Rst_n), .prog_hold(prog_hold),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc),
        .ins_comp(ins_comp), .ins_ready(ins_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    typedef struct {
        int          lat;
        int          r1;
        logic [31:0] p1;
        int          rdly;
        logic [31:0] start;
        logic [31:0] w0;
        logic [31:0] w1;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rq_t;

    logic [31:0] memw [256];
    int          lat = 1;
    int          cyc = 0;
    int          gnt_cnt = 0;
    logic [31:0] exp_addr = '0;
    rq_t         rq[$];
    exp_t        exq[$];
    int          mon_idx = 0;
    string       tag = "init";

    logic        n_req, n_gnt, n_redir, n_hold, s_rst;
    logic [31:0] n_addr, n_rpc;

    always @(negedge clk) begin
        n_req   = imem_req;
        n_gnt   = imem_gnt;
        n_addr  = imem_addr;
        n_redir = redirect_valid;
        n_rpc   = redirect_pc;
        n_hold  = prog_hold;
    end

    // In-order memory: request seen at an edge returns lat cycles later.
    always @(posedge clk) begin
        s_rst = Rst_n;
        #1;
        cyc++;
        if (!s_rst || !Rst_n) begin
            rq.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            exp_addr    = '0;
            gnt_cnt     = 0;
        end else begin
            if (n_hold || n_redir) begin
                chk({tag, " req_in_flush"}, 32'(n_req), 32'h0);
                exp_addr = n_hold ? 32'h0 : {n_rpc[31:2], 2'b00};
            end else if (n_req && n_gnt) begin
                chk({tag, " imem_addr"}, n_addr, exp_addr);
                exp_addr += 32'd4;
                gnt_cnt++;
                rq.push_back('{n_addr, cyc + lat - 1});
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memw[rq[0].addr[9:2]];
                void'(rq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (Rst_n && ins_valid && ins_ready && mon_idx < exq.size()) begin
            chk($sformatf("%s ins%0d", tag, mon_idx), ins, exq[mon_idx].ins);
            chk($sformatf("%s pc%0d", tag, mon_idx), ins_pc, exq[mon_idx].pc);
            chk($sformatf("%s comp%0d", tag, mon_idx), 32'(ins_comp), 32'(exq[mon_idx].comp));
            mon_idx++;
        end
        if (Rst_n && prog_hold)
            chk({tag, " hold_valid"}, 32'(ins_valid), 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) memw[i] = {12'(i), 20'h00013};
    endtask

    task automatic do_reset(input int l);
        Rst_n = 1'b0;
        redirect_valid = 1'b0;
        prog_hold = 1'b0;
        imem_gnt = 1'b1;
        ins_ready = 1'b1;
        lat = l;
        exq.delete();
        mon_idx = 0;
        repeat (2) step();
        Rst_n = 1'b1;
    endtask

    task automatic wait_stream(input int budget);
        for (int i = 0; i < budget && mon_idx < exq.size(); i++) @(negedge clk);
        chk({tag, " stream_done"}, 32'(mon_idx), 32'(exq.size()));
    endtask

    vec_t vt[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1, -1, 32'h0, -1, 32'h0, 32'h00000013, 32'h00000013,
                  '{32'h13, 32'h0, 1'b0}, '{32'h13, 32'h4, 1'b0}};
        vt[1] = '{1, -1, 32'h0, -1, 32'h0, 32'h45050505, 32'h00000013,
                  '{32'h0505, 32'h0, 1'b1}, '{32'h4505, 32'h2, 1'b1}};
        vt[2] = '{1, -1, 32'h0, -1, 32'h0, 32'h00134501, 32'h00000000,
                  '{32'h4501, 32'h0, 1'b1}, '{32'h13, 32'h2, 1'b0}};
        vt[3] = '{1, -1, 32'h0, -1, 32'h0, 32'h12345003, 32'h00000013,
                  '{32'h12345003, 32'h0, 1'b0}, '{32'h13, 32'h4, 1'b0}};
        vt[4] = '{3, -1, 32'h0, 2, 32'h106, 32'h45050001, 32'h00000013,
                  '{32'h4505, 32'h106, 1'b1}, '{32'h13, 32'h108, 1'b0}};
        vt[5] = '{3, -1, 32'h0, 3, 32'h106, 32'h45050001, 32'h00000013,
                  '{32'h4505, 32'h106, 1'b1}, '{32'h13, 32'h108, 1'b0}};
        vt[6] = '{1, -1, 32'h0, 2, 32'h106, 32'h45050001, 32'h00000013,
                  '{32'h4505, 32'h106, 1'b1}, '{32'h13, 32'h108, 1'b0}};
        vt[7] = '{1, -1, 32'h0, 0, 32'h202, 32'hABCF0001, 32'h00001234,
                  '{32'h1234ABCF, 32'h202, 1'b0}, '{32'h0, 32'h206, 1'b1}};
        vt[8] = '{3, 1, 32'h300, 3, 32'h106, 32'h45050001, 32'h00000013,
                  '{32'h4505, 32'h106, 1'b1}, '{32'h13, 32'h108, 1'b0}};

        // reset state
        fill();
        tag = "reset";
        #12;
        chk("reset imem_req", 32'(imem_req), 32'h0);
        chk("reset ins_valid", 32'(ins_valid), 32'h0);
        chk("reset ins", ins, 32'h0);
        chk("reset ins_comp", 32'(ins_comp), 32'h0);
        chk("reset ins_pc", ins_pc, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);

        // first request latency and back-to-back delivery
        tag = "first";
        do_reset(1);
        @(negedge clk);
        chk("first req", 32'(imem_req), 32'h1);
        chk("first addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("first lat_valid", 32'(ins_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("first valid%0d", i), 32'(ins_valid), 32'h1);
            chk($sformatf("first pc%0d", i), ins_pc, 32'(4 * i));
            chk($sformatf("first ins%0d", i), ins, memw[i]);
            chk($sformatf("first comp%0d", i), 32'(ins_comp), 32'h0);
        end

        // alignment / redirect vectors
        for (int r = 0; r < 9; r++) begin
            fill();
            memw[vt[r].start[9:2]] = vt[r].w0;
            memw[vt[r].start[9:2] + 8'd1] = vt[r].w1;
            do_reset(vt[r].lat);
            tag = $sformatf("vec%0d", r);
            exq.push_back(vt[r].e0);
            exq.push_back(vt[r].e1);
            for (int c = 0; c <= vt[r].rdly; c++) begin
                redirect_valid = (c == vt[r].r1) || (c == vt[r].rdly);
                redirect_pc = (c == vt[r].r1) ? vt[r].p1 : vt[r].start;
                step();
            end
            redirect_valid = 1'b0;
            wait_stream(60);
        end

        // straddling 32-bit waits for its second word
        fill();
        memw[0] = 32'h00134501;
        memw[1] = 32'h00000000;
        do_reset(1);
        tag = "straddle";
        exq.push_back('{32'h4501, 32'h0, 1'b1});
        step();
        imem_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("straddle hold_valid", 32'(ins_valid), 32'h0);
        chk("straddle hold_pc", ins_pc, 32'h2);
        chk("straddle first_done", 32'(mon_idx), 32'h1);
        step();
        imem_gnt = 1'b1;
        exq.push_back('{32'h00000013, 32'h2, 1'b0});
        wait_stream(30);

        // decode stalled: queue fills to DEPTH and requests stop
        fill();
        do_reset(1);
        tag = "full";
        ins_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("full imem_req", 32'(imem_req), 32'h0);
        chk("full grants", 32'(gnt_cnt), 32'(DEPTH));
        chk("full valid", 32'(ins_valid), 32'h1);
        chk("full pc", ins_pc, 32'h0);
        for (int i = 0; i < 8; i++) exq.push_back('{memw[i], 32'(4 * i), 1'b0});
        step();
        ins_ready = 1'b1;
        wait_stream(60);

        // prog_hold mid-stream restarts at RESET_PC
        fill();
        do_reset(1);
        tag = "hold";
        repeat (6) step();
        prog_hold = 1'b1;
        repeat (5) step();
        mon_idx = 0;
        exq.push_back('{memw[0], 32'h0, 1'b0});
        exq.push_back('{memw[1], 32'h4, 1'b0});
        prog_hold = 1'b0;
        @(negedge clk);
        chk("hold restart_req", 32'(imem_req), 32'h1);
        chk("hold restart_addr", imem_addr, 32'h0);
        wait_stream(30);

        // asynchronous reset while words are queued and in flight
        fill();
        do_reset(1);
        tag = "arst";
        ins_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("arst pre_valid", 32'(ins_valid), 32'h1);
        chk("arst pre_addr", imem_addr, 32'h10);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst imem_req", 32'(imem_req), 32'h0);
        chk("arst ins_valid", 32'(ins_valid), 32'h0);
        chk("arst ins", ins, 32'h0);
        chk("arst ins_comp", 32'(ins_comp), 32'h0);
        chk("arst ins_pc", ins_pc, 32'h0);
        chk("arst imem_addr", imem_addr, 32'h0);
        do_reset(1);
        exq.push_back('{memw[0], 32'h0, 1'b0});
        exq.push_back('{memw[1], 32'h4, 1'b0});
        wait_stream(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
